// File: rtl/dcache_tag_ctrl_if.sv
// Bus bundle between the dcache tag controller and its peers (CPU request
// path, tag RAM, memory fill port). master = controller side, slave = peers.
interface dcache_tag_ctrl_if #(
  parameter int TAG_BITS   = 19,
  parameter int INDEX_BITS = 8
);
  logic                  req_valid;
  logic [31:0]           req_addr;
  logic                  req_ready;
  logic                  resp_valid;
  logic                  resp_hit;
  logic                  fill_req;
  logic [31:0]           fill_addr;
  logic                  fill_done;
  logic                  tag_rden;
  logic [INDEX_BITS-1:0] tag_rdaddress;
  logic [TAG_BITS-1:0]   tag_q;
  logic                  tag_wren;
  logic [INDEX_BITS-1:0] tag_wraddress;
  logic [TAG_BITS-1:0]   tag_wdata;

  modport master (
    input  req_valid, req_addr, fill_done, tag_q,
    output req_ready, resp_valid, resp_hit, fill_req, fill_addr,
           tag_rden, tag_rdaddress, tag_wren, tag_wraddress, tag_wdata
  );

  modport slave (
    output req_valid, req_addr, fill_done, tag_q,
    input  req_ready, resp_valid, resp_hit, fill_req, fill_addr,
           tag_rden, tag_rdaddress, tag_wren, tag_wraddress, tag_wdata
  );
endinterface

// File: rtl/dcache_tag_ctrl.sv
// Dcache tag lookup / miss-fill controller with local valid bits.
// Optional whole-cache flush is enabled by defining DCACHE_TAG_CTRL_FLUSH_EN.
module dcache_tag_ctrl #(
  parameter int TAG_BITS    = 19,
  parameter int INDEX_BITS  = 8,
  parameter int OFFSET_BITS = 5
) (
  input  logic            clock,
  input  logic            reset,
  dcache_tag_ctrl_if.master bus
`ifdef DCACHE_TAG_CTRL_FLUSH_EN
  ,
  input  logic            flush_req,
  output logic            flush_done
`endif
);
  localparam int NUM_ENTRIES = 1 << INDEX_BITS;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    FILL,
    UPDATE
`ifdef DCACHE_TAG_CTRL_FLUSH_EN
    ,
    FLUSH
`endif
  } state_t;

  state_t                 state;
  state_t                 next_state;
  logic [TAG_BITS-1:0]    r_tag;
  logic [INDEX_BITS-1:0]  r_idx;
  logic [NUM_ENTRIES-1:0] valid_bits;
  logic [INDEX_BITS-1:0]  req_idx;
  logic [TAG_BITS-1:0]    req_tag;
  logic                   flush_go;
  logic                   accept;
  logic                   hit;
  logic [INDEX_BITS-1:0]  flush_cnt;
  logic                   flush_last;

  assign req_idx = bus.req_addr[OFFSET_BITS +: INDEX_BITS];
  assign req_tag = bus.req_addr[OFFSET_BITS+INDEX_BITS +: TAG_BITS];

`ifdef DCACHE_TAG_CTRL_FLUSH_EN
  assign flush_go   = (state == IDLE) && flush_req;
  assign flush_last = (state == FLUSH) && (flush_cnt == {INDEX_BITS{1'b1}});
`else
  assign flush_go   = 1'b0;
  assign flush_last = 1'b0;
`endif

  // A pending flush takes priority over a CPU request sitting in IDLE.
  assign accept = (state == IDLE) && bus.req_valid && !flush_go;
  assign hit    = valid_bits[r_idx] && (bus.tag_q == r_tag);

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_tag <= '0;
      r_idx <= '0;
    end else if (accept) begin
      r_tag <= req_tag;
      r_idx <= req_idx;
    end
  end

  // Valid bits are set by a completed fill and cleared by reset or flush.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_bits <= '0;
      flush_cnt  <= '0;
    end else begin
      if (state == UPDATE) begin
        valid_bits[r_idx] <= 1'b1;
      end
`ifdef DCACHE_TAG_CTRL_FLUSH_EN
      if (state == FLUSH) begin
        valid_bits[flush_cnt] <= 1'b0;
        flush_cnt             <= flush_cnt + 1'b1;
      end else begin
        flush_cnt <= '0;
      end
`endif
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (flush_go) begin
`ifdef DCACHE_TAG_CTRL_FLUSH_EN
          next_state = FLUSH;
`endif
        end else if (bus.req_valid) begin
          next_state = LOOKUP;
        end
      end
      LOOKUP:  next_state = hit ? IDLE : FILL;
      FILL:    next_state = bus.fill_done ? UPDATE : FILL;
      UPDATE:  next_state = IDLE;
`ifdef DCACHE_TAG_CTRL_FLUSH_EN
      FLUSH:   next_state = flush_last ? IDLE : FLUSH;
`endif
      default: next_state = IDLE;
    endcase
  end

  // All outputs are forced low while reset is asserted.
  always_comb begin
    bus.req_ready     = 1'b0;
    bus.resp_valid    = 1'b0;
    bus.resp_hit      = 1'b0;
    bus.fill_req      = 1'b0;
    bus.fill_addr     = {r_tag, r_idx, {OFFSET_BITS{1'b0}}};
    bus.tag_rden      = 1'b0;
    bus.tag_rdaddress = r_idx;
    bus.tag_wren      = 1'b0;
    bus.tag_wraddress = r_idx;
    bus.tag_wdata     = r_tag;
`ifdef DCACHE_TAG_CTRL_FLUSH_EN
    flush_done        = 1'b0;
`endif
    case (state)
      IDLE: begin
        bus.req_ready     = !flush_go;
        bus.tag_rden      = accept;
        bus.tag_rdaddress = req_idx;
      end
      LOOKUP: begin
        bus.resp_valid = 1'b1;
        bus.resp_hit   = hit;
      end
      FILL: begin
        bus.fill_req = 1'b1;
      end
      UPDATE: begin
        bus.tag_wren   = 1'b1;
        bus.resp_valid = 1'b1;
        bus.resp_hit   = 1'b1;
      end
`ifdef DCACHE_TAG_CTRL_FLUSH_EN
      FLUSH: begin
        bus.tag_wren      = 1'b1;
        bus.tag_wraddress = flush_cnt;
        bus.tag_wdata     = '0;
        flush_done        = flush_last;
      end
`endif
      default: ;
    endcase
    if (reset) begin
      bus.req_ready     = 1'b0;
      bus.resp_valid    = 1'b0;
      bus.resp_hit      = 1'b0;
      bus.fill_req      = 1'b0;
      bus.fill_addr     = '0;
      bus.tag_rden      = 1'b0;
      bus.tag_rdaddress = '0;
      bus.tag_wren      = 1'b0;
      bus.tag_wraddress = '0;
      bus.tag_wdata     = '0;
`ifdef DCACHE_TAG_CTRL_FLUSH_EN
      flush_done        = 1'b0;
`endif
    end
  end
endmodule

// File: tb/tb_dcache_tag_ctrl.sv
// Scoreboard bench for dcache_tag_ctrl: directed accesses push expected
// responses, fill addresses and tag writes; a negedge monitor pops and checks.
module tb_dcache_tag_ctrl;
  logic clock = 1'b0;
  logic reset = 1'b1;

  dcache_tag_ctrl_if #(.TAG_BITS(19), .INDEX_BITS(8)) bus ();

`ifdef DCACHE_TAG_CTRL_FLUSH_EN
  logic flush_req = 1'b0;
  logic flush_done;
`endif

  dcache_tag_ctrl #(.TAG_BITS(19), .INDEX_BITS(8), .OFFSET_BITS(5)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.master)
`ifdef DCACHE_TAG_CTRL_FLUSH_EN
    ,
    .flush_req  (flush_req),
    .flush_done (flush_done)
`endif
  );

  always #5 clock = ~clock;

  // Tag RAM model: one-cycle registered read.
  logic [18:0] tag_mem [256];
  always @(posedge clock) begin
    if (bus.tag_wren) tag_mem[bus.tag_wraddress] <= bus.tag_wdata;
    if (bus.tag_rden) bus.tag_q <= tag_mem[bus.tag_rdaddress];
  end

  int n_checks = 0;
  int n_fail   = 0;
  bit          resp_q [$];
  logic [31:0] fill_q [$];
  logic [26:0] wr_q   [$];
  bit          flushing = 1'b0;
  bit          fill_seen = 1'b0;
  int          accept_count = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents an event.
  always @(negedge clock) begin
    if (!reset) begin
      if (bus.req_valid && bus.req_ready) accept_count++;
      if (bus.resp_valid) begin
        checkOutput("resp_expected", 32'(resp_q.size() > 0), 32'd1);
        if (resp_q.size() > 0) checkOutput("resp_hit", 32'(bus.resp_hit), 32'(resp_q.pop_front()));
      end
      if (bus.fill_req && !fill_seen) begin
        checkOutput("fill_expected", 32'(fill_q.size() > 0), 32'd1);
        if (fill_q.size() > 0) checkOutput("fill_addr", bus.fill_addr, fill_q.pop_front());
      end
      if (bus.tag_wren && !flushing) begin
        checkOutput("write_expected", 32'(wr_q.size() > 0), 32'd1);
        if (wr_q.size() > 0) checkOutput("tag_write", 32'({bus.tag_wraddress, bus.tag_wdata}), 32'(wr_q.pop_front()));
      end
    end
    fill_seen = bus.fill_req;
  end

  task automatic acceptRequest(input logic [31:0] addr, input bit hold);
    bit accepted;
    accepted = 1'b0;
    @(posedge clock); #1;
    bus.req_valid = 1'b1;
    bus.req_addr  = addr;
    for (int i = 0; i < 50 && !accepted; i++) begin
      @(negedge clock);
      if (bus.req_ready) accepted = 1'b1;
    end
    checkOutput("accept_timeout", 32'(accepted), 32'd1);
    @(posedge clock); #1;
    if (!hold) bus.req_valid = 1'b0;
  endtask

  // One access; on a miss the fill completes fill_wait cycles after fill_req rises.
  task automatic applyStimulus(input logic [31:0] addr, input bit exp_hit, input int fill_wait);
    resp_q.push_back(exp_hit);
    if (!exp_hit) begin
      resp_q.push_back(1'b1);
      fill_q.push_back({addr[31:5], 5'b0});
      wr_q.push_back({addr[12:5], addr[31:13]});
    end
    acceptRequest(addr, 1'b0);
    @(negedge clock);
    checkOutput("resp_latency", 32'(bus.resp_valid), 32'd1);
    if (exp_hit) begin
      @(negedge clock);
      checkOutput("ready_after_hit", 32'(bus.req_ready), 32'd1);
      checkOutput("no_fill_on_hit", 32'(bus.fill_req), 32'd0);
    end else begin
      @(negedge clock);
      checkOutput("fill_req_start", 32'(bus.fill_req), 32'd1);
      repeat (fill_wait) @(negedge clock);
      @(posedge clock); #1 bus.fill_done = 1'b1;
      @(posedge clock); #1 bus.fill_done = 1'b0;
      @(negedge clock);
      checkOutput("update_wren", 32'(bus.tag_wren), 32'd1);
      @(negedge clock);
      checkOutput("ready_after_fill", 32'(bus.req_ready), 32'd1);
    end
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.fill_done = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    checkOutput("ready_in_reset", 32'(bus.req_ready), 32'd0);
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    checkOutput("reset_ready", 32'(bus.req_ready), 32'd1);
    checkOutput("reset_resp", 32'(bus.resp_valid), 32'd0);
    checkOutput("reset_fill", 32'(bus.fill_req), 32'd0);
    checkOutput("reset_wren", 32'(bus.tag_wren), 32'd0);
    checkOutput("reset_rden", 32'(bus.tag_rden), 32'd0);

    // Cold miss (index 0xB3, tag 0x091A2), then hit.
    applyStimulus(32'h1234_5660, 1'b0, 2);
    applyStimulus(32'h1234_5660, 1'b1, 0);
    // Conflict on index 0xB3 with tag 0x40000 evicts the first line.
    applyStimulus(32'h8000_1660, 1'b0, 0);
    applyStimulus(32'h8000_1660, 1'b1, 0);
    applyStimulus(32'h1234_5660, 1'b0, 3);
    applyStimulus(32'h1234_5660, 1'b1, 0);
    applyStimulus(32'h0000_0040, 1'b0, 1);
    applyStimulus(32'h0000_0040, 1'b1, 0);

    // Reset while a fill is outstanding.
    resp_q.push_back(1'b0);
    fill_q.push_back(32'h0ABC_DE20);
    acceptRequest(32'h0ABC_DE20, 1'b0);
    @(negedge clock);
    @(negedge clock);
    checkOutput("fill_before_reset", 32'(bus.fill_req), 32'd1);
    @(posedge clock); #1 reset = 1'b1;
    @(negedge clock);
    checkOutput("fill_in_reset", 32'(bus.fill_req), 32'd0);
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    checkOutput("fill_after_reset", 32'(bus.fill_req), 32'd0);
    bus.fill_done = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checkOutput("late_done_wren", 32'(bus.tag_wren), 32'd0);
    end
    bus.fill_done = 1'b0;
    applyStimulus(32'h1234_5660, 1'b0, 0);

    // Backpressure: request held high through LOOKUP and FILL.
    accept_count = 0;
    resp_q.push_back(1'b0);
    resp_q.push_back(1'b1);
    fill_q.push_back(32'h7FFF_FFE0);
    wr_q.push_back({8'hFF, 19'h3FFFF});
    acceptRequest(32'h7FFF_FFE0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      checkOutput("bp_ready_low", 32'(bus.req_ready), 32'd0);
    end
    @(posedge clock); #1 bus.fill_done = 1'b1;
    @(posedge clock); #1 bus.fill_done = 1'b0;
    bus.req_valid = 1'b0;
    @(negedge clock);
    checkOutput("bp_ready_update", 32'(bus.req_ready), 32'd0);
    @(negedge clock);
    checkOutput("bp_accept_once", 32'(accept_count), 32'd1);
    applyStimulus(32'h7FFF_FFE0, 1'b1, 0);

`ifdef DCACHE_TAG_CTRL_FLUSH_EN
    begin
      int wr_cnt;
      int done_cnt;
      bit finished;
      applyStimulus(32'h0000_2000, 1'b0, 0);
      applyStimulus(32'h0000_1FE0, 1'b0, 0);
      applyStimulus(32'h0000_2000, 1'b1, 0);
      applyStimulus(32'h0000_1FE0, 1'b1, 0);
      wr_cnt = 0;
      done_cnt = 0;
      finished = 1'b0;
      flushing = 1'b1;
      @(posedge clock); #1 flush_req = 1'b1;
      bus.req_valid = 1'b1;
      bus.req_addr  = 32'h0000_2000;
      @(negedge clock);
      checkOutput("flush_ready_low", 32'(bus.req_ready), 32'd0);
      @(posedge clock); #1 flush_req = 1'b0;
      bus.req_valid = 1'b0;
      for (int i = 0; i < 300 && !finished; i++) begin
        @(negedge clock);
        if (bus.tag_wren && bus.tag_wdata == '0) wr_cnt++;
        if (flush_done) done_cnt++;
        if (bus.req_ready) finished = 1'b1;
      end
      flushing = 1'b0;
      checkOutput("flush_wren_cycles", 32'(wr_cnt), 32'd256);
      checkOutput("flush_done_once", 32'(done_cnt), 32'd1);
      applyStimulus(32'h0000_2000, 1'b0, 0);
      applyStimulus(32'h0000_1FE0, 1'b0, 0);
    end
`endif

    repeat (3) @(negedge clock);
    checkOutput("resp_q_empty", 32'(resp_q.size()), 32'd0);
    checkOutput("fill_q_empty", 32'(fill_q.size()), 32'd0);
    checkOutput("wr_q_empty", 32'(wr_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
